// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multicycle multiply/divide unit:
//   - FSM state encodings (MDU_IDLE / MDU_RUN / MDU_DONE)
//   - op codes and op-port width
//   - iteration count MDU_ITER
//   - step-mode selector used between the top and mdu_step
// Configuration macro: MDU_UNSIGNED_EN widens op to 2 bits and enables
// multu/divu. Without it op is 1 bit (0 = mult, 1 = div, both signed).
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

`ifdef MDU_UNSIGNED_EN
    localparam int OP_W = 2;
`else
    localparam int OP_W = 1;
`endif

    // Full 2-bit op codes. A 1-bit op zero-extends onto the signed pair.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // What one iteration of the shared datapath does.
    typedef enum logic [1:0] {
        STEP_BOOTH = 2'd0,  // signed radix-2 Booth
        STEP_MULU  = 2'd1,  // unsigned shift-add
        STEP_DIV   = 2'd2   // restoring division on magnitudes
    } step_mode_e;

endpackage

// File: rtl/mult_div_unit_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// Purely combinational single iteration of the multiply/divide datapath.
// Computes next {acc, mq, q_-1} for one Booth step, one unsigned shift-add
// step, or one restoring-division step, selected by mode.
// Ports:
//   mode     step_mode_e encoding (STEP_BOOTH / STEP_MULU / STEP_DIV)
//   m        multiplicand, or divisor magnitude
//   acc      accumulator / partial remainder
//   mq       multiplier (shifting out) / dividend shifting into quotient
//   qm1      Booth q_-1 bit
//   *_nxt    values after this step
// Configuration macro MDU_UNSIGNED_EN only decides whether STEP_MULU is ever
// selected; this block always implements it.
// -----------------------------------------------------------------------------
module mdu_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic             qm1,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt,
    output logic             qm1_nxt
);

    logic [WIDTH:0] sum;     // one guard bit so acc +/- m never overflows
    logic [WIDTH:0] rem_sh;  // partial remainder shifted left by one
    logic           ge;

    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path leaves it unassigned and no latch can be inferred.
        acc_nxt = acc;
        mq_nxt  = mq;
        qm1_nxt = qm1;
        sum     = '0;
        rem_sh  = '0;
        ge      = 1'b0;

        unique case (mode)
            STEP_BOOTH: begin
                sum = {acc[WIDTH-1], acc};
                if (mq[0] && !qm1) begin
                    sum = sum - {m[WIDTH-1], m};
                end else if (!mq[0] && qm1) begin
                    sum = sum + {m[WIDTH-1], m};
                end
                // The guard bit carries the true sign, so dropping the LSB of
                // this concatenation is the arithmetic shift right by one.
                {acc_nxt, mq_nxt, qm1_nxt} = {sum, mq};
            end
            STEP_MULU: begin
                sum = {1'b0, acc} + (mq[0] ? {1'b0, m} : '0);
                {acc_nxt, mq_nxt, qm1_nxt} = {sum, mq};
            end
            STEP_DIV: begin
                rem_sh  = {acc, mq[WIDTH-1]};
                ge      = (rem_sh >= {1'b0, m});
                // Result is below m, so the low WIDTH bits are exact.
                acc_nxt = ge ? (rem_sh[WIDTH-1:0] - m) : rem_sh[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], ge};
                qm1_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply/divide unit feeding the Hi/Lo registers.
// 33 cycles from accepted start to done; divide-by-zero finishes in one.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     request, sampled only in IDLE
//   op        0 mult, 1 div (2 bits with MDU_UNSIGNED_EN: 00 mult, 01 div,
//             10 multu, 11 divu)
//   src_a     multiplicand / dividend
//   src_b     multiplier / divisor
//   busy      high while iterating
//   done      one-cycle pulse, results valid
//   div_zero  pulses with done for a divide by zero
//   hi_out    product high half / remainder
//   lo_out    product low half / quotient
// Configuration macro: MDU_UNSIGNED_EN (see package).
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mdu_state_e       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [WIDTH-1:0] mq_q,       mq_d;
    logic             qm1_q,      qm1_d;
    logic [WIDTH-1:0] m_q,        m_d;
    step_mode_e       mode_q,     mode_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;

    logic [WIDTH-1:0] step_acc, step_mq;
    logic             step_qm1;

    // Operand decode for the accepting edge.
    logic [1:0]       op_full;
    logic             in_div, in_uns, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_full = 2'(op);
    assign in_div  = (op_full == OP_DIV)   || (op_full == OP_DIVU);
    assign in_uns  = (op_full == OP_MULTU) || (op_full == OP_DIVU);
    assign a_neg   = src_a[WIDTH-1] & ~in_uns;
    assign b_neg   = src_b[WIDTH-1] & ~in_uns;
    // Negating the most negative value wraps to itself, which read as
    // unsigned is exactly its magnitude.
    assign a_mag   = a_neg ? -src_a : src_a;
    assign b_mag   = b_neg ? -src_b : src_b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode    (mode_q),
        .m       (m_q),
        .acc     (acc_q),
        .mq      (mq_q),
        .qm1     (qm1_q),
        .acc_nxt (step_acc),
        .mq_nxt  (step_mq),
        .qm1_nxt (step_qm1)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        mode_d     = mode_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    if (in_div && (src_b == '0)) begin
                        // No iterations; hi/lo deliberately left untouched.
                        state_d    = MDU_DONE;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = MDU_RUN;
                        cnt_d     = '0;
                        acc_d     = '0;
                        qm1_d     = 1'b0;
                        neg_quo_d = in_div & (a_neg ^ b_neg);
                        neg_rem_d = in_div & a_neg;
                        if (in_div) begin
                            mode_d = STEP_DIV;
                            mq_d   = a_mag;
                            m_d    = b_mag;
                        end else begin
                            mode_d = (op_full == OP_MULT) ? STEP_BOOTH : STEP_MULU;
                            mq_d   = src_b;
                            m_d    = src_a;
                        end
                    end
                end
            end
            MDU_RUN: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                qm1_d = step_qm1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = MDU_DONE;
                    cnt_d   = '0;
                    // Results come straight from the final step so they land
                    // on the same edge that enters DONE.
                    if (mode_q == STEP_DIV) begin
                        lo_d = neg_quo_q ? -step_mq  : step_mq;
                        hi_d = neg_rem_q ? -step_acc : step_acc;
                    end else begin
                        lo_d = step_mq;
                        hi_d = step_acc;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase

        busy_d = (state_d == MDU_RUN);
        done_d = (state_d == MDU_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the datapath registers are cleared along with control so
            // an aborted run leaves no partial product or remainder behind.
            state_q    <= MDU_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            mode_q     <= STEP_BOOTH;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            mode_q     <= mode_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule
